// File: rtl/pe_feeder.sv
// Systolic-array operand feeder: buffers K weight/activation vector pairs, then
// streams them diagonally skewed into the array edge and drains the pipeline.
module pe_feeder #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] k_len,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [8*COLS-1:0]          ld_w,
  input  logic [8*ROWS-1:0]          ld_a,
  output logic [8*COLS-1:0]          out_w_port,
  output logic [8*ROWS-1:0]          out_a_port,
  output logic                       fire,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int DRN   = ROWS + COLS - 2;
  localparam int KW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + MAXRC + DRN + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [8*COLS-1:0] ow_q, ow_d;
  logic [8*ROWS-1:0] oa_q, oa_d;
  logic              fire_q, fire_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [8*COLS-1:0] wbuf [DEPTH];
  logic [8*ROWS-1:0] abuf [DEPTH];

  logic              ld_acc;
  logic [CW-1:0]     tn;
  logic [8*COLS-1:0] diag_w;
  logic [8*ROWS-1:0] diag_a;

  assign ld_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign ld_acc     = ld_ready && ld_valid;
  assign out_w_port = ow_q;
  assign out_a_port = oa_q;
  assign fire       = fire_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (ld_acc) begin
      wbuf[cnt_q[AW-1:0]] <= ld_w;
      abuf[cnt_q[AW-1:0]] <= ld_a;
    end
  end

  // Stream index of the cycle being registered next; the final LOAD beat
  // produces t=0, so that beat's data is bypassed around the buffer.
  assign tn = (state_q == S_STREAM) ? cnt_q + CW'(1) : '0;

  always_comb begin
    diag_w = '0;
    diag_a = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      automatic int idx = int'(tn) - int'(c);
      if (idx >= 0 && idx < int'(k_q)) begin
        if (state_q == S_LOAD && idx == int'(cnt_q))
          diag_w[8*(COLS-1-c) +: 8] = ld_w[8*(COLS-1-c) +: 8];
        else
          diag_w[8*(COLS-1-c) +: 8] = wbuf[AW'(idx)][8*(COLS-1-c) +: 8];
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      automatic int idx = int'(tn) - int'(r);
      if (idx >= 0 && idx < int'(k_q)) begin
        if (state_q == S_LOAD && idx == int'(cnt_q))
          diag_a[8*(ROWS-1-r) +: 8] = ld_a[8*(ROWS-1-r) +: 8];
        else
          diag_a[8*(ROWS-1-r) +: 8] = abuf[AW'(idx)][8*(ROWS-1-r) +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    ow_d    = '0;
    oa_d    = '0;
    fire_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0 && int'(k_len) <= DEPTH) begin
            k_d     = k_len;
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          if (int'(cnt_q) + 1 == int'(k_q)) begin
            cnt_d   = '0;
            state_d = S_STREAM;
            ow_d    = diag_w;
            oa_d    = diag_a;
            fire_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_STREAM: begin
        if (int'(cnt_q) == int'(k_q) + MAXRC - 2) begin
          cnt_d = '0;
          if (DRN == 0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          ow_d   = diag_w;
          oa_d   = diag_a;
          fire_d = (int'(cnt_q) + 1 < int'(k_q));
        end
      end
      S_DRAIN: begin
        if (int'(cnt_q) == DRN - 1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      ow_q    <= '0;
      oa_q    <= '0;
      fire_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      ow_q    <= ow_d;
      oa_q    <= oa_d;
      fire_q  <= fire_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized self-checking bench for pe_feeder (ROWS=COLS=2, DEPTH=4) against a
// spec-level model of the skewed stream, fire, busy and done timing.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  k_len = '0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_w = '0;
  logic [15:0] ld_a = '0;
  logic        ld_ready, fire, busy, done, err;
  logic [15:0] out_w_port, out_a_port;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        min_rdy;
  logic [15:0] mw [4];
  logic [15:0] ma [4];
  logic [36:0] obs_v [16];

  pe_feeder #(.ROWS(2), .COLS(2), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_w(ld_w), .ld_a(ld_a),
    .out_w_port(out_w_port), .out_a_port(out_a_port),
    .fire(fire), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected {out_w, out_a, fire, done, busy, err, ld_ready} at cycle t after
  // the LOAD->STREAM edge: stream K+1 cycles, drain 2, done at t=K+3.
  function automatic logic [36:0] exp_vec(input int t, input int k);
    logic [15:0] ew, ea;
    ew = '0;
    ea = '0;
    if (t < k + 1) begin
      for (int lane = 0; lane < 2; lane++) begin
        int j;
        j = t - lane;
        if (j >= 0 && j < k) begin
          ew[15-8*lane -: 8] = mw[j][15-8*lane -: 8];
          ea[15-8*lane -: 8] = ma[j][15-8*lane -: 8];
        end
      end
    end
    return {ew, ea, (t < k), (t == k + 3), (t < k + 3), 1'b0, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 4; i++) begin
      mw[i] = 16'($urandom);
      ma[i] = 16'($urandom);
    end
  endtask

  task automatic do_start(input int k);
    start = 1'b1;
    k_len = 3'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic do_load(input int k, input int gmin, input int gmax);
    min_rdy = 1'b1;
    for (int i = 0; i < k; i++) begin
      ld_valid = 1'b1;
      ld_w = mw[i];
      ld_a = ma[i];
      if (!ld_ready) min_rdy = 1'b0;
      tick();
      if (i < k - 1) begin
        int g;
        g = int'($urandom_range(gmax, gmin));
        ld_valid = 1'b0;
        ld_w = 16'($urandom);
        ld_a = 16'($urandom);
        repeat (g) begin
          if (!ld_ready) min_rdy = 1'b0;
          tick();
        end
      end
    end
    ld_valid = 1'b0;
    ld_w = 16'($urandom);
    ld_a = 16'($urandom);
  endtask

  task automatic collect(input int n, input int start_at);
    for (int i = 0; i < n; i++) begin
      obs_v[i] = {out_w_port, out_a_port, fire, done, busy, err, ld_ready};
      start = (i == start_at);
      k_len = 3'd1;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({ld_ready, fire, busy, done, err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {ld_ready, fire, busy, done, err});
    end
    n_cmp++;
    if ({out_w_port, out_a_port} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00000000", {out_w_port, out_a_port});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    mw[0] = 16'h0102; ma[0] = 16'h0304;
    mw[1] = 16'h0506; ma[1] = 16'h0708;
    do_start(2);
    do_load(2, 0, 0);
    collect(7, -1);
    for (int t = 0; t < 7; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_vec(t, 2)) begin
        n_bad++;
        $display("FAIL basic t=%0d: got %h want %h", t, obs_v[t], exp_vec(t, 2));
      end
    end
    n_cmp++;
    if ({obs_v[0][36:5], obs_v[1][36:5], obs_v[2][36:5]} !== 96'h0100_0300_0502_0704_0006_0008) begin
      n_bad++;
      $display("FAIL basic_literal: got %h %h %h", obs_v[0][36:5], obs_v[1][36:5], obs_v[2][36:5]);
    end
  endtask

  task automatic test_bad_len();
    int bad [2];
    bad[0] = 0;
    bad[1] = int'($urandom_range(7, 5));
    for (int i = 0; i < 2; i++) begin
      do_start(bad[i]);
      n_cmp++;
      if ({err, busy} !== 2'b10) begin
        n_bad++;
        $display("FAIL bad_len_pulse k=%0d: got err,busy=%b want 10", bad[i], {err, busy});
      end
      tick();
      n_cmp++;
      if ({err, busy} !== 2'b00) begin
        n_bad++;
        $display("FAIL bad_len_after k=%0d: got err,busy=%b want 00", bad[i], {err, busy});
      end
    end
  endtask

  task automatic test_backpressure();
    fill_rand();
    do_start(3);
    do_load(3, 4, 4);
    collect(8, -1);
    n_cmp++;
    if (min_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ready_in_load: got %b want 1", min_rdy);
    end
    for (int t = 0; t < 8; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_vec(t, 3)) begin
        n_bad++;
        $display("FAIL backpressure t=%0d: got %h want %h", t, obs_v[t], exp_vec(t, 3));
      end
    end
  endtask

  task automatic test_start_busy();
    int k;
    k = int'($urandom_range(4, 2));
    fill_rand();
    do_start(k);
    do_load(k, 0, 1);
    collect(k + 5, 1);
    for (int t = 0; t < k + 5; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_vec(t, k)) begin
        n_bad++;
        $display("FAIL start_busy k=%0d t=%0d: got %h want %h", k, t, obs_v[t], exp_vec(t, k));
      end
    end
  endtask

  task automatic test_reset_mid();
    mw[0] = 16'($urandom); ma[0] = 16'($urandom);
    mw[1] = 16'($urandom); ma[1] = 16'($urandom);
    do_start(2);
    do_load(2, 0, 0);
    tick();
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({out_w_port, out_a_port, fire, done, busy, err, ld_ready} !== 37'h0) begin
      n_bad++;
      $display("FAIL reset_mid_async: got %h want 0",
               {out_w_port, out_a_port, fire, done, busy, err, ld_ready});
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_mid_no_done i=%0d: got done,busy=%b want 00", i, {done, busy});
      end
    end
    fill_rand();
    do_start(1);
    do_load(1, 0, 0);
    collect(6, -1);
    for (int t = 0; t < 6; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_vec(t, 1)) begin
        n_bad++;
        $display("FAIL reset_mid_k1 t=%0d: got %h want %h", t, obs_v[t], exp_vec(t, 1));
      end
    end
  endtask

  task automatic test_k_max();
    int nfire, done_at;
    fill_rand();
    do_start(4);
    do_load(4, 0, 2);
    collect(9, -1);
    nfire = 0;
    done_at = -1;
    for (int t = 0; t < 9; t++) begin
      if (obs_v[t][4]) nfire++;
      if (obs_v[t][3] && done_at < 0) done_at = t;
      n_cmp++;
      if (obs_v[t] !== exp_vec(t, 4)) begin
        n_bad++;
        $display("FAIL k_max t=%0d: got %h want %h", t, obs_v[t], exp_vec(t, 4));
      end
    end
    n_cmp++;
    if (nfire != 4 || done_at != 7) begin
      n_bad++;
      $display("FAIL k_max_timing: got fire=%0d done_at=%0d want fire=4 done_at=7", nfire, done_at);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int k;
      k = int'($urandom_range(4, 1));
      fill_rand();
      do_start(k);
      do_load(k, 0, 2);
      collect(k + 5, -1);
      for (int t = 0; t < k + 5; t++) begin
        n_cmp++;
        if (obs_v[t] !== exp_vec(t, k)) begin
          n_bad++;
          $display("FAIL random it=%0d k=%0d t=%0d: got %h want %h", it, k, t, obs_v[t], exp_vec(t, k));
        end
      end
      repeat (int'($urandom_range(2, 0))) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_k_max();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter ROWS, default 16, number of array rows (activation lanes).
REQ-002 Parameter COLS, default 16, number of array columns (weight lanes).
REQ-003 Parameter DEPTH, default 16, maximum reduction length K that can be buffered.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a tile; sampled only in IDLE.
REQ-007 k_len  input  clog2(DEPTH+1)  reduction length K, sampled with start.
REQ-008 ld_valid  input  1  load beat valid.
REQ-009 ld_ready  output  1  load beat accepted when high together with ld_valid.
REQ-010 ld_w  input  8*COLS  one weight vector; lane c occupies bits [8c : 8c+7] (bit 0 is the MSB side).
REQ-011 ld_a  input  8*ROWS  one activation vector, with the same lane packing as ld_w.
REQ-012 out_w_port  output  8*COLS  skewed weights, driving the array's top-row weight inputs.
REQ-013 out_a_port  output  8*ROWS  skewed activations, driving the array's left-column activation inputs.
REQ-014 fire  output  1  array fire input; marks valid lane-0 data.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at tile completion.
REQ-017 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-018 The block SHALL implement four states: IDLE, LOAD, STREAM, DRAIN.
REQ-019 IDLE transitions:
- start with 1<=k_len<=DEPTH: latch K, clear the beat counter, go to LOAD next cycle.
- start with any other k_len: pulse err the next cycle and stay in IDLE.
REQ-020 LOAD behaviour:
- ld_ready=1.
- On each ld_valid&&ld_ready, write ld_w and ld_a into buffer entry n, then increment n.
- After beat K is accepted, go to STREAM; ld_ready SHALL be 0 from the next cycle.
REQ-021 LOAD stalls:
- ld_valid low: wait indefinitely.
- No timeout.
REQ-022 STREAM SHALL last exactly K+max(ROWS,COLS)-1 cycles, indexed t=0,1,...
REQ-023 During STREAM cycle t, the registered outputs SHALL hold:
- weight lane c = W[t-c][c] when 0<=t-c<K, else 0x00.
- activation lane r = A[t-r][r] when 0<=t-r<K, else 0x00.
REQ-024 fire SHALL be 1 exactly for STREAM cycles t=0..K-1 and 0 otherwise.
REQ-025 STREAM timing:
- Outputs are registered.
- Cycle t=0 is the first cycle after the LOAD→STREAM edge.
REQ-026 DRAIN SHALL last ROWS+COLS-2 cycles with all data outputs 0 and fire 0, so the last operands can propagate to PE(ROWS-1,COLS-1).
REQ-027 DRAIN SHALL then pulse done for one cycle and return to IDLE in that same cycle.
REQ-028 When ROWS+COLS-2 is 0, DRAIN SHALL be skipped and done SHALL pulse on the cycle after the last STREAM cycle.
REQ-029 start asserted while busy SHALL be ignored: no err and no state change.
REQ-030 Outside STREAM, out_w_port and out_a_port SHALL be all zero.
REQ-031 Data SHALL pass through bit-exact; the block performs no arithmetic on data and has no sign semantics.
REQ-032 K=1 is legal and SHALL produce a single diagonal with fire high for one cycle.

Reset
REQ-033 While rstn=0, regardless of clk:
- State SHALL be IDLE.
- ld_ready, fire, busy, done, err SHALL be 0.
- out_w_port and out_a_port SHALL be 0.
- Counters SHALL be 0.
REQ-034 Buffer contents need not be reset.
REQ-035 Reset asserted mid-LOAD or mid-STREAM SHALL abort the tile with no done pulse.
REQ-036 After reset release, the first accepted start SHALL behave as from power-up.

Verification (ROWS=COLS=2, DEPTH=4)
REQ-037 Basic tile:
- Stimulus: start, k_len=2; load W0=0x0102, A0=0x0304, W1=0x0506, A1=0x0708.
- out_w lanes: t0 {01,00}, t1 {05,02}, t2 {00,06}.
- out_a lanes: t0 {03,00}, t1 {07,04}, t2 {00,08}.
- fire high at t0 and t1; DRAIN lasts 2 cycles; done pulses once.
REQ-038 Bad length:
- start with k_len=0 → err pulse, busy stays 0.
- start with k_len=5 → err pulse, busy stays 0.
REQ-039 LOAD backpressure:
- Stimulus: K=3 with ld_valid deasserted for 4 cycles between beats.
- Required: stream identical to the no-gap case; ld_ready=0 from the first cycle after the third beat.
REQ-040 Start while busy:
- Stimulus: start pulsed during STREAM.
- Required: ignored; the tile completes normally and no err is raised.
REQ-041 Reset mid-operation:
- Stimulus: rstn low for 1 cycle at STREAM t=1.
- Required: all outputs 0 immediately (asynchronously), no done; a following K=1 tile streams correctly.
REQ-042 K=DEPTH=4:
- fire high for exactly 4 cycles.
- STREAM lasts 5 cycles.
- done occurs 7 cycles after the LOAD→STREAM edge.
